// File: rtl/accum_readout_if.sv
// rtl/accum_readout_if.sv - accumulator readout bus: start, acc mux side, result handshake
interface accum_readout_if;
    logic        start;
    logic        busy;
    logic [7:0]  acc_data;
    logic [1:0]  acc_sel;
    logic        freeze;
    logic [15:0] sum;
    logic [7:0]  count;
    logic [7:0]  carry;
    logic        overflow;
    logic        result_valid;
    logic        result_ready;

    modport master (
        input  start, acc_data, result_ready,
        output busy, acc_sel, freeze, sum, count, carry, overflow, result_valid
    );

    modport slave (
        output start, acc_data, result_ready,
        input  busy, acc_sel, freeze, sum, count, carry, overflow, result_valid
    );
endinterface

// File: rtl/accum_readout.sv
// rtl/accum_readout.sv - steps the accumulator output mux and captures a coherent snapshot
module accum_readout #(
    parameter int         SETTLE_CYCLES          = 1,
    parameter logic [1:0] MUX_SEL_COUNTER_VALUE  = 2'd0,
    parameter logic [1:0] MUX_SEL_COUNTER_CARRY  = 2'd1,
    parameter logic [1:0] MUX_SEL_REGISTER_2_LSB = 2'd2,
    parameter logic [1:0] MUX_SEL_REGISTER_2_MSB = 2'd3,
    parameter logic [1:0] IDLE_SEL               = MUX_SEL_REGISTER_2_LSB
) (
    input  logic               clock,
    input  logic               reset,
    accum_readout_if.master    bus
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("accum_readout: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAP_MSB   = 3'd1,
        CAP_LSB   = 3'd2,
        CAP_CNT   = 3'd3,
        CAP_CARRY = 3'd4,
        VALID     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        freeze_q, freeze_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  carry_q, carry_d;
    logic        ovf_q, ovf_d;

    // cnt_q counts the remaining settle edges; the capture happens on the edge where it reads zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CAP_MSB;
                    sel_d   = MUX_SEL_REGISTER_2_MSB;
                    cnt_d   = SETTLE;
                end
            end
            CAP_MSB: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d[15:8] = bus.acc_data;
                    state_d     = CAP_LSB;
                    sel_d       = MUX_SEL_REGISTER_2_LSB;
                    cnt_d       = SETTLE;
                end
            end
            CAP_LSB: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d[7:0] = bus.acc_data;
                    state_d    = CAP_CNT;
                    sel_d      = MUX_SEL_COUNTER_VALUE;
                    cnt_d      = SETTLE;
                end
            end
            CAP_CNT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    count_d = bus.acc_data;
                    state_d = CAP_CARRY;
                    sel_d   = MUX_SEL_COUNTER_CARRY;
                    cnt_d   = SETTLE;
                end
            end
            CAP_CARRY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    carry_d = bus.acc_data;
                    ovf_d   = |bus.acc_data;
                    state_d = VALID;
                    sel_d   = IDLE_SEL;
                    cnt_d   = 4'd0;
                end
            end
            VALID: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = IDLE_SEL;
                cnt_d   = 4'd0;
            end
        endcase

        freeze_d = (state_d == CAP_MSB) || (state_d == CAP_LSB) ||
                   (state_d == CAP_CNT) || (state_d == CAP_CARRY);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == VALID);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sel_q    <= IDLE_SEL;
            freeze_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sum_q    <= 16'd0;
            count_q  <= 8'd0;
            carry_q  <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            freeze_q <= freeze_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.acc_sel      = sel_q;
    assign bus.freeze       = freeze_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.sum          = sum_q;
    assign bus.count        = count_q;
    assign bus.carry        = carry_q;
    assign bus.overflow     = ovf_q;

endmodule

// File: doc/accum_readout.md
Name: accum_readout

Overview:
Downstream stage of the AdderAccumulator. It takes a coherent snapshot of the accumulator state on request. It does this by stepping the accumulator's output_sel mux through its four sources and capturing each byte of data_out. The assembled 16-bit sum, counter byte and carry byte are presented on a valid/ready handshake to the consumer (host/display logic). While the snapshot is in progress, it asserts freeze so the upstream operand controller stops issuing load/add.

Parameters:
SETTLE_CYCLES, 1, cycles to wait after changing acc_sel before data_out is sampled; legal range 1..15
IDLE_SEL, `MUX_SEL_REGISTER_2_LSB, acc_sel value driven while idle or presenting a result

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  snapshot request; sampled only in IDLE
acc_data  input  8  AdderAccumulator data_out
acc_sel  output  2  drives AdderAccumulator output_sel; codes from mux_sel.vh
freeze  output  1  high while capturing; upstream must hold load=0, add=0
busy  output  1  high in any state other than IDLE
sum  output  16  captured {REGISTER_2_MSB, REGISTER_2_LSB}
count  output  8  captured COUNTER_VALUE byte
carry  output  8  captured COUNTER_CARRY byte
overflow  output  1  registered OR-reduction of captured carry
result_valid  output  1  snapshot available
result_ready  input  1  consumer accepts snapshot

Behaviour:
- Interface: one clock (clock); reset (reset) is asynchronous, active-high. All outputs are registered.
- Reset values:
  - acc_sel=IDLE_SEL
  - freeze=0, busy=0, result_valid=0
  - sum=0, count=0, carry=0, overflow=0
  - state=IDLE, settle counter=0
- States and transitions:
  - IDLE -> CAP_MSB on a clock edge with start=1.
  - CAP_MSB -> CAP_LSB -> CAP_CNT -> CAP_CARRY -> VALID.
  - VALID -> IDLE on an edge with result_ready=1.
- On entry to each CAP_x state (same edge):
  - acc_sel is set to the x source: `MUX_SEL_REGISTER_2_MSB, `MUX_SEL_REGISTER_2_LSB, `MUX_SEL_COUNTER_VALUE, `MUX_SEL_COUNTER_CARRY respectively.
  - The settle counter loads SETTLE_CYCLES.
- Each CAP_x state lasts SETTLE_CYCLES+1 cycles. On its final edge, acc_data is written to the field and the state advances.
- Latency, with start accepted at edge T0:
  - field k (k=0..3) select changes at T0+k(S+1) and is captured at T0+(k+1)(S+1);
  - result_valid rises at T0+4(S+1). With S=1 this is 8 cycles.
- freeze is high from edge T0 until the CAP_CARRY capture edge inclusive. It is low in VALID and IDLE.
- On the CAP_CARRY capture edge, overflow is set to |acc_data. It updates on that same edge.
- acc_sel returns to IDLE_SEL on entry to VALID.
- Output fields hold their last captured values indefinitely. They change only on their own capture edge, so during a new snapshot the fields are a mix of old and new until result_valid.
- Handshake:
  - result_valid stays high, with fields stable, until an edge with result_ready=1. result_valid then drops on that edge.
  - result_ready while not VALID is ignored.
- start while busy is ignored, with no queuing. start=1 coincident with the accept edge in VALID is ignored; it must be re-presented in IDLE.
- Reset mid-snapshot aborts immediately and asynchronously to the reset values. No partial result is flagged.
- SETTLE_CYCLES outside 1..15 is a configuration error. An elaboration-time $display/$finish is acceptable.

Test Plan:
- Basic snapshot: behavioural acc model returns MSB=0x12, LSB=0x34, CNT=0x05, CARRY=0x00; pulse start -> result_valid at exactly 8 edges later; sum=0x1234, count=0x05, carry=0x00, overflow=0; acc_sel sequence MSB,LSB,CNT,CARRY each held 2 cycles.
- Overflow: model CARRY=0x03, MSB=0xFF, LSB=0xFE -> sum=0xFFFE, carry=0x03, overflow=1.
- Backpressure: hold result_ready=0 for 10 cycles after valid -> result_valid and fields stable; model bytes changed meanwhile do not alter outputs; ready=1 -> valid drops next edge, busy=0.
- start while busy and at accept edge: pulse start during CAP_LSB and together with ready -> no second snapshot; fresh start in IDLE -> new snapshot with updated values.
- Reset mid-operation: assert reset asynchronously during CAP_CNT -> all outputs are the reset values immediately, before the next clock edge; freeze=0; acc_sel=IDLE_SEL.
- SETTLE_CYCLES=3 build: freeze high 16 cycles; result_valid at T0+16; each acc_sel held 4 cycles.
